seq_lock_monitor: RTL and testbench
===================================

Name: seq_lock_monitor

Overview:
- Downstream consumer of the byte-sequence detector's 8-bit status code.
- Decodes the code into a stage index and checks that every code-to-code step is a legal detector transition.
- Qualifies a stable lock after a programmable dwell in the final code, and keeps saturating event counters for lock acquisitions and aborted partial sequences.
- Results feed status registers and debug LEDs.

Parameters:
- LOCK_CYCLES, 4, consecutive samples of code 0x11 needed to declare lock (range 1..255).
- CNT_W, 8, width of lock_cnt and abort_cnt.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_val  input  8  detector status code, sampled every cycle.
- clr  input  1  synchronous clear of counters and error capture.
- stage  output  3  decoded stage of last legal code.
- lock  output  1  qualified lock.
- lock_rise  output  1  one-cycle pulse on lock 0->1.
- lock_cnt  output  CNT_W  lock acquisitions, saturating.
- abort_cnt  output  CNT_W  partial sequences abandoned, saturating.
- err  output  1  sticky illegal code or illegal transition.
- err_code  output  8  in_val that caused the first error.

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high, and dominates all other inputs.
- Reset values:
  - stage=0, lock=0, lock_rise=0, lock_cnt=0, abort_cnt=0, err=0, err_code=0x00.
  - Internal prev=0x00, dwell=0.
- Latency: all outputs are registered; an in_val sampled at edge N is reflected after edge N.
- Legal codes and stage decode:
  - 0x00 -> 0 (detector in reset), 0x01 -> 0.
  - 0x03 -> 1, 0x05 -> 2, 0x09 -> 3, 0x11 -> 4.
- Legal transitions (prev -> in_val):
  - Self-loop on any legal code.
  - 0x00->0x01, 0x01->0x03, 0x03->0x05, 0x05->0x09, 0x09->0x11.
  - 0x03/0x05/0x09/0x11 -> 0x01.
  - Any code -> 0x00.
- Illegal case: in_val not a legal code, or a disallowed transition. Required response:
  - If err=0: set err=1 and capture err_code=in_val. Later errors leave err_code unchanged.
  - stage holds its previous value.
  - prev forced to 0x00 (resynchronise); dwell=0; lock=0.
  - No counter increments.
- Legal case: prev<=in_val; stage<=decode(in_val).
- Abort: a legal transition from 0x03, 0x05 or 0x09 to 0x01 increments abort_cnt. 0x11->0x01 is a lock loss, not an abort.
- Dwell and lock:
  - dwell increments on each sampled 0x11 and saturates at LOCK_CYCLES. Any other sample clears it to 0.
  - lock=1 exactly while dwell==LOCK_CYCLES, so lock rises at the edge that captures the LOCK_CYCLES-th consecutive 0x11.
  - lock falls at the edge that samples any non-0x11 value.
- lock_rise is high for exactly the cycle in which lock first reads 1. lock_cnt increments on that same edge.
- Saturation: both counters stop at 2^CNT_W-1 with no wrap.
- clr clears lock_cnt, abort_cnt, err and err_code. It does not touch stage, prev, dwell, lock or lock_rise.
- clr in the same cycle as an increment or error capture: clr wins, and the result is 0 (err=0).
- rst mid-sequence: all state returns to reset values at that edge, including a lock already in progress.
- LOCK_CYCLES=1: lock rises on the edge that captures the first 0x11 after 0x09.

Decomposition:
- Shared package seq_codes_pkg holds:
  - The code constants 0x00/0x01/0x03/0x05/0x09/0x11, which the detector also uses.
  - The 3-bit stage encoding and a decode function.
  - The legal-transition function.
- One sub-module, sat_cnt (parameter W; inputs inc, clr). It is instantiated twice, for lock_cnt and abort_cnt.
- Dwell counter and lock logic stay in the top block.

Test Plan:
- Reset: hold rst 2 cycles with in_val=0x5A. Required: all outputs at reset values and err=0, because rst dominates.
- Full sequence: 0x00,0x01,0x03,0x05,0x09, then 0x11 x4 (LOCK_CYCLES=4). Required:
  - stage steps 0,0,1,2,3,4.
  - lock=1 after the 4th 0x11, with lock_rise pulsing in that cycle only.
  - lock_cnt=1.
  - A following 0x01 drops lock the next cycle.
- Abort and short dwell:
  - 0x01,0x03,0x05,0x01 -> abort_cnt=1, stage=0.
  - 0x01,0x03,0x05,0x09, then 0x11 x3, then 0x01 -> lock never asserts; abort_cnt unchanged.
- Illegal jump: 0x01 then 0x09 -> err=1, err_code=0x09, stage stays 0. Then 0x7F -> err_code still 0x09. Then 0x01,0x03 -> stage=1.
- Saturation (CNT_W=2): five full lock/unlock sequences -> lock_cnt=3.
- clr collision: assert clr in the lock_rise cycle -> lock_cnt=0 after the edge, and lock stays 1.

Source files
------------

// File: rtl/seq_codes_pkg.sv
// Shared status-code definitions for the byte-sequence detector and its consumers.
// Holds the detector's code constants, the stage encoding, the code-to-stage decode
// and the legal-transition rule between consecutive codes.
package seq_codes_pkg;

    localparam logic [7:0] CodeReset = 8'h00;
    localparam logic [7:0] CodeIdle  = 8'h01;
    localparam logic [7:0] CodeS1    = 8'h03;
    localparam logic [7:0] CodeS2    = 8'h05;
    localparam logic [7:0] CodeS3    = 8'h09;
    localparam logic [7:0] CodeS4    = 8'h11;

    typedef enum logic [2:0] {
        StageIdle = 3'd0,
        Stage1    = 3'd1,
        Stage2    = 3'd2,
        Stage3    = 3'd3,
        Stage4    = 3'd4
    } stage_e;

    function automatic logic is_legal_code(input logic [7:0] code);
        return (code == CodeReset) || (code == CodeIdle) || (code == CodeS1) ||
               (code == CodeS2) || (code == CodeS3) || (code == CodeS4);
    endfunction

    // Only meaningful for legal codes; anything else maps to idle.
    function automatic stage_e decode_stage(input logic [7:0] code);
        stage_e st;
        unique case (code)
            CodeS1:  st = Stage1;
            CodeS2:  st = Stage2;
            CodeS3:  st = Stage3;
            CodeS4:  st = Stage4;
            default: st = StageIdle;
        endcase
        return st;
    endfunction

    // Assumes cur is already a legal code.
    function automatic logic is_legal_step(input logic [7:0] prev, input logic [7:0] cur);
        logic ok;
        ok = (cur == prev) || (cur == CodeReset);
        unique case (prev)
            CodeReset: ok = ok || (cur == CodeIdle);
            CodeIdle:  ok = ok || (cur == CodeS1);
            CodeS1:    ok = ok || (cur == CodeS2) || (cur == CodeIdle);
            CodeS2:    ok = ok || (cur == CodeS3) || (cur == CodeIdle);
            CodeS3:    ok = ok || (cur == CodeS4) || (cur == CodeIdle);
            CodeS4:    ok = ok || (cur == CodeIdle);
            default:   ok = ok;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   inc  - count one event this cycle
//   clr  - synchronous clear, wins over inc
//   cnt  - current count, stops at all-ones
module sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_lock_monitor.sv
// Monitors the detector status code: decodes the stage, flags illegal codes or
// transitions (sticky, first offending code captured), qualifies lock after a dwell
// in the final code, and counts lock acquisitions and aborted partial sequences.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   in_val     - detector status code, sampled every cycle
//   clr        - clears counters and error capture
//   stage      - stage of last legal code
//   lock       - qualified lock
//   lock_rise  - one-cycle pulse on lock 0->1
//   lock_cnt   - lock acquisitions (saturating)
//   abort_cnt  - abandoned partial sequences (saturating)
//   err        - sticky error flag
//   err_code   - in_val that raised the first error
module seq_lock_monitor
    import seq_codes_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_val,
    input  logic             clr,
    output logic [2:0]       stage,
    output logic             lock,
    output logic             lock_rise,
    output logic [CNT_W-1:0] lock_cnt,
    output logic [CNT_W-1:0] abort_cnt,
    output logic             err,
    output logic [7:0]       err_code
);

    localparam logic [7:0] DwellMax = 8'(LOCK_CYCLES);

    logic [7:0] prev_d, prev_q;
    stage_e     stage_d, stage_q;
    logic [7:0] dwell_d, dwell_q;
    logic       lock_d, lock_q;
    logic       lock_rise_d, lock_rise_q;
    logic       err_d, err_q;
    logic [7:0] err_code_d, err_code_q;
    logic       legal;
    logic       abort_inc;

    always_comb begin
        prev_d     = prev_q;
        stage_d    = stage_q;
        dwell_d    = dwell_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        abort_inc  = 1'b0;

        legal = is_legal_code(in_val) && is_legal_step(prev_q, in_val);

        if (!legal) begin
            // Resynchronise to the detector-reset code so the next 0x01 is accepted.
            prev_d  = CodeReset;
            dwell_d = '0;
            if (!err_q) begin
                err_d      = 1'b1;
                err_code_d = in_val;
            end
        end else begin
            prev_d  = in_val;
            stage_d = decode_stage(in_val);
            if (in_val == CodeS4) begin
                dwell_d = (dwell_q == DwellMax) ? dwell_q : dwell_q + 8'd1;
            end else begin
                dwell_d = '0;
            end
            // Falling back to idle from a mid-sequence stage; 0x11->0x01 is a lock loss.
            abort_inc = (in_val == CodeIdle) &&
                        ((prev_q == CodeS1) || (prev_q == CodeS2) || (prev_q == CodeS3));
        end

        if (clr) begin
            err_d      = 1'b0;
            err_code_d = '0;
        end

        lock_d      = (dwell_d == DwellMax);
        lock_rise_d = lock_d && !lock_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= CodeReset;
            stage_q     <= StageIdle;
            dwell_q     <= '0;
            lock_q      <= 1'b0;
            lock_rise_q <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            prev_q      <= prev_d;
            stage_q     <= stage_d;
            dwell_q     <= dwell_d;
            lock_q      <= lock_d;
            lock_rise_q <= lock_rise_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    sat_cnt #(
        .W (CNT_W)
    ) u_lock_cnt (
        .clk (clk),
        .rst (rst),
        .inc (lock_rise_d),
        .clr (clr),
        .cnt (lock_cnt)
    );

    sat_cnt #(
        .W (CNT_W)
    ) u_abort_cnt (
        .clk (clk),
        .rst (rst),
        .inc (abort_inc),
        .clr (clr),
        .cnt (abort_cnt)
    );

    assign stage     = stage_q;
    assign lock      = lock_q;
    assign lock_rise = lock_rise_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_seq_lock_monitor.sv
// Bench for seq_lock_monitor: two instances share the stimulus, one with the default
// parameters (dwell 4, 8-bit counters) and one with dwell 1 and 2-bit counters.
module tb_seq_lock_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_val;
    logic       clr;
    bit         chk_en = 1'b0;

    logic [2:0] a_stage, b_stage;
    logic       a_lock, b_lock, a_rise, b_rise, a_err, b_err;
    logic [7:0] a_lcnt, a_acnt, a_ecode, b_ecode;
    logic [1:0] b_lcnt, b_acnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_lock_monitor #(.LOCK_CYCLES(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_val(in_val), .clr(clr),
        .stage(a_stage), .lock(a_lock), .lock_rise(a_rise), .lock_cnt(a_lcnt),
        .abort_cnt(a_acnt), .err(a_err), .err_code(a_ecode)
    );

    seq_lock_monitor #(.LOCK_CYCLES(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_val(in_val), .clr(clr),
        .stage(b_stage), .lock(b_lock), .lock_rise(b_rise), .lock_cnt(b_lcnt),
        .abort_cnt(b_acnt), .err(b_err), .err_code(b_ecode)
    );

    // ---------------- behavioural model ----------------
    // Codes form a chain 00,01,03,05,09,11; position in it gives legality and stage.
    function automatic int chain_pos(input int c);
        case (c)
            'h00: return 0;
            'h01: return 1;
            'h03: return 2;
            'h05: return 3;
            'h09: return 4;
            'h11: return 5;
            default: return -1;
        endcase
    endfunction

    int lc_need[2] = '{4, 1};
    int cnt_max[2] = '{255, 3};
    int m_prev[2], m_stage[2], m_dwell[2], m_lock[2], m_rise[2];
    int m_lcnt[2], m_acnt[2], m_err[2], m_ecode[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic int v = int'(in_val);
            automatic int pp = chain_pos(m_prev[i]);
            automatic int pv = chain_pos(v);
            automatic int st = m_stage[i], pr = m_prev[i], dw = m_dwell[i];
            automatic int lc = m_lcnt[i], ac = m_acnt[i], er = m_err[i], ec = m_ecode[i];
            automatic int lk;
            automatic int rs;
            automatic bit ok;
            ok = (pv >= 0) && (v == m_prev[i] || v == 0 || pv == pp + 1 ||
                               (v == 1 && pp >= 2));
            if (!ok) begin
                if (er == 0) begin er = 1; ec = v; end
                pr = 0;
                dw = 0;
            end else begin
                if (v == 1 && pp >= 2 && pp <= 4) ac = (ac < cnt_max[i]) ? ac + 1 : ac;
                pr = v;
                st = (pv == 0) ? 0 : pv - 1;
                dw = (v == 'h11) ? ((dw < lc_need[i]) ? dw + 1 : dw) : 0;
            end
            lk = (dw == lc_need[i]) ? 1 : 0;
            rs = (lk == 1 && m_lock[i] == 0) ? 1 : 0;
            if (rs == 1) lc = (lc < cnt_max[i]) ? lc + 1 : lc;
            if (clr) begin lc = 0; ac = 0; er = 0; ec = 0; end
            if (rst) begin
                st = 0; pr = 0; dw = 0; lk = 0; rs = 0; lc = 0; ac = 0; er = 0; ec = 0;
            end
            m_prev[i]  <= pr;
            m_stage[i] <= st;
            m_dwell[i] <= dw;
            m_lock[i]  <= lk;
            m_rise[i]  <= rs;
            m_lcnt[i]  <= lc;
            m_acnt[i]  <= ac;
            m_err[i]   <= er;
            m_ecode[i] <= ec;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("a.stage", int'(a_stage), m_stage[0]);
            check("a.lock", int'(a_lock), m_lock[0]);
            check("a.lock_rise", int'(a_rise), m_rise[0]);
            check("a.lock_cnt", int'(a_lcnt), m_lcnt[0]);
            check("a.abort_cnt", int'(a_acnt), m_acnt[0]);
            check("a.err", int'(a_err), m_err[0]);
            check("a.err_code", int'(a_ecode), m_ecode[0]);
            check("b.stage", int'(b_stage), m_stage[1]);
            check("b.lock", int'(b_lock), m_lock[1]);
            check("b.lock_rise", int'(b_rise), m_rise[1]);
            check("b.lock_cnt", int'(b_lcnt), m_lcnt[1]);
            check("b.abort_cnt", int'(b_acnt), m_acnt[1]);
            check("b.err", int'(b_err), m_err[1]);
            check("b.err_code", int'(b_ecode), m_ecode[1]);
        end
    end

    // Apply one sample; on return the outputs reflect it.
    task automatic step(input logic [7:0] v, input logic c);
        in_val = v;
        clr    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic run_lock_seq();
        step(8'h01, 0); step(8'h03, 0); step(8'h05, 0); step(8'h09, 0);
        for (int k = 0; k < 4; k++) step(8'h11, 0);
        step(8'h01, 0);
    endtask

    initial begin
        rst = 1'b1; in_val = 8'h5A; clr = 1'b0;
        step(8'h5A, 0);
        step(8'h5A, 0);
        check("rst.stage", int'(a_stage), 0);
        check("rst.lock", int'(a_lock), 0);
        check("rst.err", int'(a_err), 0);
        check("rst.err_code", int'(a_ecode), 0);
        check("rst.lock_cnt", int'(a_lcnt), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Full sequence
        step(8'h00, 0); step(8'h01, 0);
        step(8'h03, 0); check("full.stage1", int'(a_stage), 1);
        step(8'h05, 0); step(8'h09, 0); check("full.stage3", int'(a_stage), 3);
        step(8'h11, 0);
        check("full.b_lock_first", int'(b_lock), 1);
        check("full.b_rise_first", int'(b_rise), 1);
        step(8'h11, 0); step(8'h11, 0);
        check("full.a_lock_3rd", int'(a_lock), 0);
        step(8'h11, 0);
        check("full.a_lock", int'(a_lock), 1);
        check("full.a_rise", int'(a_rise), 1);
        check("full.a_lock_cnt", int'(a_lcnt), 1);
        check("full.stage4", int'(a_stage), 4);
        step(8'h11, 0);
        check("full.a_rise_once", int'(a_rise), 0);
        step(8'h01, 0);
        check("full.a_lock_drop", int'(a_lock), 0);
        check("full.no_abort", int'(a_acnt), 0);

        // Abort, then short dwell
        step(8'h01, 0); step(8'h03, 0); step(8'h05, 0); step(8'h01, 0);
        check("abort.cnt", int'(a_acnt), 1);
        check("abort.stage", int'(a_stage), 0);
        step(8'h03, 0); step(8'h05, 0); step(8'h09, 0);
        step(8'h11, 0); step(8'h11, 0); step(8'h11, 0);
        check("short.no_lock", int'(a_lock), 0);
        step(8'h01, 0);
        check("short.abort_same", int'(a_acnt), 1);

        // Illegal jump and sticky capture
        step(8'h01, 0); step(8'h09, 0);
        check("ill.err", int'(a_err), 1);
        check("ill.err_code", int'(a_ecode), 'h09);
        check("ill.stage_hold", int'(a_stage), 0);
        step(8'h7F, 0);
        check("ill.code_sticky", int'(a_ecode), 'h09);
        step(8'h01, 0); step(8'h03, 0);
        check("ill.resync_stage", int'(a_stage), 1);

        // clr clears error; clr collides with lock_rise
        step(8'h00, 1);
        check("clr.err", int'(a_err), 0);
        check("clr.abort", int'(a_acnt), 0);
        step(8'h01, 0); step(8'h03, 0); step(8'h05, 0); step(8'h09, 0);
        step(8'h11, 0); step(8'h11, 0); step(8'h11, 0);
        step(8'h11, 1);
        check("clrcol.lock", int'(a_lock), 1);
        check("clrcol.rise", int'(a_rise), 1);
        check("clrcol.lock_cnt", int'(a_lcnt), 0);
        step(8'h01, 0);

        // Saturation of the 2-bit counter
        for (int s = 0; s < 5; s++) run_lock_seq();
        check("sat.b_lock_cnt", int'(b_lcnt), 3);
        check("sat.a_lock_cnt", int'(a_lcnt), 5);

        // rst while locked
        step(8'h01, 0); step(8'h03, 0); step(8'h05, 0); step(8'h09, 0);
        for (int k = 0; k < 4; k++) step(8'h11, 0);
        rst = 1'b1;
        step(8'h11, 0);
        check("rstmid.lock", int'(a_lock), 0);
        check("rstmid.lock_cnt", int'(a_lcnt), 0);
        rst = 1'b0;

        // clr colliding with error capture, then a fresh capture
        step(8'h7F, 1);
        check("clrerr.err", int'(a_err), 0);
        step(8'h7F, 0);
        check("err2.code", int'(a_ecode), 'h7F);
        step(8'h00, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
